// File: rtl/dds_dac_out_pkg.sv
// -----------------------------------------------------------------------------
// dds_dac_out_pkg
// Shared constants for the DDS 1-bit DAC output stage.
//   SAMPLE_W    : default sample width, equal to the DDS core's waveform width
//   MODE_PWM    : mode encoding for left-aligned PWM rendering
//   MODE_SD     : mode encoding for first-order sigma-delta rendering
//   buf_state_e : occupancy of the single-entry pending sample buffer
// -----------------------------------------------------------------------------
package dds_dac_out_pkg;

  localparam int   SAMPLE_W = 12;

  localparam logic MODE_PWM = 1'b0;
  localparam logic MODE_SD  = 1'b1;

  typedef enum logic {
    BUF_EMPTY = 1'b0,
    BUF_FULL  = 1'b1
  } buf_state_e;

endpackage

// File: rtl/dds_dac_out_if.sv
// -----------------------------------------------------------------------------
// dds_dac_out_if
// Valid/ready sample stream from the DDS output mux into the DAC stage.
//   data  : W-bit unsigned sample
//   valid : data is valid; the source holds data while ready is low
//   ready : sink can take a sample this cycle
// Modports: master = sample source (DDS), slave = dds_dac_out.
// -----------------------------------------------------------------------------
interface dds_dac_out_if
  import dds_dac_out_pkg::*;
#(
  parameter int W = SAMPLE_W
) ();

  logic [W-1:0] data;
  logic         valid;
  logic         ready;

  modport master (output data, output valid, input  ready);
  modport slave  (input  data, input  valid, output ready);

endinterface

// File: rtl/dds_dac_out_sd_mod1.sv
// -----------------------------------------------------------------------------
// dds_dac_out_sd_mod1
// First-order sigma-delta modulator (single accumulator, carry out = bit).
//   clk    : system clock
//   rst    : synchronous active-high reset, clears the accumulator
//   ce     : advance the accumulator this cycle
//   clr    : clear the accumulator (wins over ce)
//   din    : W-bit unsigned input level
//   sd_bit : carry of acc + din for the current cycle (combinational; the
//            parent registers it)
// Over 2^W consecutive ce-ticks with constant din the accumulator returns to
// its starting value, so exactly din carries are produced per frame.
// -----------------------------------------------------------------------------
module dds_dac_out_sd_mod1
  import dds_dac_out_pkg::*;
#(
  parameter int W = SAMPLE_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ce,
  input  logic         clr,
  input  logic [W-1:0] din,
  output logic         sd_bit
);

  logic [W-1:0] acc;
  logic [W:0]   sum;

  assign sum    = {1'b0, acc} + {1'b0, din};
  assign sd_bit = sum[W];

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      acc <= '0;
    end else if (ce) begin
      acc <= sum[W-1:0];
    end
  end

endmodule

// File: rtl/dds_dac_out.sv
// -----------------------------------------------------------------------------
// dds_dac_out
// 1-bit DAC output stage behind the two-voice DDS core. Samples arrive over a
// valid/ready stream into a pending buffer; at every frame boundary (2^W
// ce-ticks) the pending sample becomes the active sample and is rendered for
// one full frame as left-aligned PWM or first-order sigma-delta.
//
// Ports
//   clk         : system clock
//   rst         : synchronous active-high reset
//   ce          : tick enable; counters and the modulator advance only on ce
//   s           : sample stream (slave side); ready = pending buffer empty
//   mode        : 0 = PWM, 1 = sigma-delta; sampled at the frame boundary only
//   dac_out     : registered 1-bit DAC output
//   frame_start : one-clk pulse after a frame boundary is taken
//   underrun    : one-clk pulse when a boundary finds no pending sample
//
// Pending buffer FSM
//   state     | meaning
//   BUF_EMPTY | no sample waiting, s.ready = 1
//   BUF_FULL  | pend_buf holds the next frame's sample, s.ready = 0
// -----------------------------------------------------------------------------
module dds_dac_out
  import dds_dac_out_pkg::*;
#(
  parameter int W = SAMPLE_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ce,
  dds_dac_out_if.slave  s,
  input  logic          mode,
  output logic          dac_out,
  output logic          frame_start,
  output logic          underrun
);

  localparam logic [W-1:0] CNT_LAST = '1;

  buf_state_e   buf_state;
  buf_state_e   buf_next;

  logic [W-1:0] cnt;
  logic [W-1:0] active;
  logic [W-1:0] pend_buf;
  logic         mode_q;

  logic         pend;
  logic         accept;
  logic         boundary;
  logic         pwm_bit;
  logic         sd_ce;
  logic         sd_clr;
  logic         sd_out;

  assign pend     = (buf_state == BUF_FULL);
  assign s.ready  = !pend;
  assign accept   = s.valid && !pend;
  assign boundary = ce && (cnt == CNT_LAST);

  // Left-aligned pulse: high for the first 'active' ticks of the frame.
  assign pwm_bit  = (cnt < active);

  // The accumulator only runs while sigma-delta is rendering; a mode change
  // at the boundary restarts it from zero so the new frame is exact.
  assign sd_ce    = ce && (mode_q == MODE_SD);
  assign sd_clr   = boundary && (mode != mode_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      buf_state <= BUF_EMPTY;
    end else begin
      buf_state <= buf_next;
    end
  end

  // accept implies EMPTY and consume implies FULL, so they never coincide;
  // an accept on the boundary cycle simply lands for the following frame.
  always_comb begin
    buf_next = buf_state;
    case (buf_state)
      BUF_EMPTY: if (s.valid)  buf_next = BUF_FULL;
      BUF_FULL:  if (boundary) buf_next = BUF_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      active      <= '0;
      pend_buf    <= '0;
      mode_q      <= MODE_PWM;
      dac_out     <= 1'b0;
      frame_start <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      underrun    <= 1'b0;

      if (accept) begin
        pend_buf <= s.data;
      end

      if (ce) begin
        cnt     <= cnt + 1'b1;
        dac_out <= (mode_q == MODE_SD) ? sd_out : pwm_bit;

        if (boundary) begin
          mode_q      <= mode;
          frame_start <= 1'b1;
          if (pend) begin
            active <= pend_buf;
          end else begin
            // Keep the previous sample so the output repeats, not drops.
            underrun <= 1'b1;
          end
        end
      end
    end
  end

  dds_dac_out_sd_mod1 #(
    .W (W)
  ) u_sd_mod1 (
    .clk    (clk),
    .rst    (rst),
    .ce     (sd_ce),
    .clr    (sd_clr),
    .din    (active),
    .sd_bit (sd_out)
  );

endmodule

// File: tb/tb_dds_dac_out.sv
// -----------------------------------------------------------------------------
// tb_dds_dac_out
// Self-checking bench for dds_dac_out. A frame-level reference model (pending
// queue, active sample, tick position inside the frame, closed-form PWM and
// sigma-delta bit rules) predicts every output on every clock, while directed
// table rows and hand-written sequences check per-frame totals and timing.
// -----------------------------------------------------------------------------
module tb_dds_dac_out;
  import dds_dac_out_pkg::*;

  localparam int W     = SAMPLE_W;
  localparam int FRAME = 1 << W;
  localparam int NROWS = 8;

  typedef struct {
    logic md;
    int   smp;
    int   ones;
    int   run;
  } row_t;

  logic clk = 1'b0;
  logic rst;
  logic ce;
  logic mode;
  logic dac_out;
  logic frame_start;
  logic underrun;

  dds_dac_out_if #(.W(W)) s_if ();

  dds_dac_out #(.W(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .ce          (ce),
    .s           (s_if),
    .mode        (mode),
    .dac_out     (dac_out),
    .frame_start (frame_start),
    .underrun    (underrun)
  );

  always #5 clk = ~clk;

  int   n_tests = 0;
  int   n_fail  = 0;

  // reference model state
  int   pq[$];
  int   m_active;
  int   m_tick;
  logic m_mode;
  logic e_dac;
  logic e_fs;
  logic e_ur;

  // automatic sample source
  int   src_q[$];
  bit   src_auto;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Ones produced by a sigma-delta frame starting from an empty accumulator:
  // tick k emits 1 when floor((k+1)*a / 2^W) steps past floor(k*a / 2^W).
  function automatic logic sd_ref(input int a, input int k);
    return (((k + 1) * a) / FRAME) != ((k * a) / FRAME);
  endfunction

  task automatic model_update(input logic c_rst, input logic c_ce, input logic c_valid,
                              input logic [W-1:0] c_data, input logic c_mode);
    bit acc_ok;
    if (c_rst) begin
      pq.delete();
      m_active = 0;
      m_tick   = 0;
      m_mode   = MODE_PWM;
      e_dac    = 1'b0;
      e_fs     = 1'b0;
      e_ur     = 1'b0;
    end else begin
      acc_ok = c_valid && (pq.size() == 0);
      e_fs   = 1'b0;
      e_ur   = 1'b0;
      if (c_ce) begin
        e_dac = (m_mode == MODE_SD) ? sd_ref(m_active, m_tick) : (m_tick < m_active);
        if (m_tick == FRAME - 1) begin
          e_fs   = 1'b1;
          m_mode = c_mode;
          if (pq.size() > 0) m_active = pq.pop_front();
          else               e_ur = 1'b1;
          m_tick = 0;
        end else begin
          m_tick++;
        end
      end
      if (acc_ok) pq.push_back(int'(c_data));
    end
  endtask

  task automatic drive_src();
    if (src_auto) begin
      s_if.valid = (src_q.size() > 0);
      s_if.data  = (src_q.size() > 0) ? W'(src_q[0]) : '0;
    end
  endtask

  task automatic step();
    logic         c_rst, c_ce, c_valid, c_ready, c_mode;
    logic [W-1:0] c_data;
    c_rst   = rst;
    c_ce    = ce;
    c_valid = s_if.valid;
    c_ready = s_if.ready;
    c_mode  = mode;
    c_data  = s_if.data;
    @(posedge clk);
    model_update(c_rst, c_ce, c_valid, c_data, c_mode);
    if (src_auto && c_valid && c_ready && !c_rst && src_q.size() > 0) void'(src_q.pop_front());
    #1;
    check("dac_out", dac_out, e_dac);
    check("frame_start", frame_start, e_fs);
    check("underrun", underrun, e_ur);
    check("s_ready", s_if.ready, (pq.size() == 0));
    drive_src();
  endtask

  task automatic wait_fs(input int max, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (frame_start !== 1'b1 && n < max);
    check("frame_start_reached", frame_start, 1'b1);
  endtask

  task automatic measure(input int len, output int ones, output int run, output int fs_pos,
                         output int rdy_low, output bit ur_seen);
    bit in_run;
    in_run  = 1'b1;
    ones    = 0;
    run     = 0;
    fs_pos  = 0;
    rdy_low = 0;
    ur_seen = 1'b0;
    for (int i = 1; i <= len; i++) begin
      step();
      if (dac_out === 1'b1) begin
        ones++;
        if (in_run) run++;
      end else begin
        in_run = 1'b0;
      end
      if (frame_start === 1'b1 && fs_pos == 0) fs_pos = i;
      if (s_if.ready === 1'b0) rdy_low++;
      if (underrun === 1'b1) ur_seen = 1'b1;
    end
  endtask

  initial begin
    int   n, ones, run, fs_pos, rdy_low, zeros;
    bit   ur_seen;
    row_t tbl [NROWS];

    tbl[0] = '{MODE_PWM, 'h111,  273,  273};
    tbl[1] = '{MODE_PWM, 'h222,  546,  546};
    tbl[2] = '{MODE_PWM, 'h400, 1024, 1024};
    tbl[3] = '{MODE_PWM, 'h000,    0,    0};
    tbl[4] = '{MODE_SD,  'h800, 2048,    0};
    tbl[5] = '{MODE_SD,  'h001,    1,    0};
    tbl[6] = '{MODE_SD,  'h555, 1365,    0};
    tbl[7] = '{MODE_PWM, 'hFFF, 4095, 4095};

    rst        = 1'b1;
    ce         = 1'b1;
    mode       = MODE_PWM;
    s_if.valid = 1'b0;
    s_if.data  = '0;
    src_auto   = 1'b0;
    m_active   = 0;
    m_tick     = 0;
    m_mode     = MODE_PWM;
    e_dac      = 1'b0;
    e_fs       = 1'b0;
    e_ur       = 1'b0;

    step();
    step();
    rst = 1'b0;

    // idle: boundaries every frame, each one an underrun, output stays low
    wait_fs(FRAME + 16, n);
    check("idle_first_frame_len", n, FRAME);
    check("idle_underrun_with_fs", underrun, 1'b1);
    measure(FRAME, ones, run, fs_pos, rdy_low, ur_seen);
    check("idle_ones", ones, 0);
    check("idle_frame_period", fs_pos, FRAME);
    check("idle_underrun_second", underrun, 1'b1);
    check("idle_ready_low_cycles", rdy_low, 0);

    // table rows streamed back to back with s_valid held high (backpressure)
    src_auto = 1'b1;
    for (int i = 0; i < NROWS; i++) src_q.push_back(tbl[i].smp);
    src_q.push_back(FRAME - 1);
    mode = tbl[0].md;
    drive_src();
    wait_fs(FRAME + 16, n);
    check("lead_frame_len", n, FRAME);
    check("lead_no_underrun", underrun, 1'b0);
    check("lead_ready_after_fs", s_if.ready, 1'b1);
    for (int i = 0; i < NROWS; i++) begin
      mode = (i < NROWS - 1) ? tbl[i + 1].md : MODE_PWM;
      measure(FRAME, ones, run, fs_pos, rdy_low, ur_seen);
      check($sformatf("row%0d_ones", i), ones, tbl[i].ones);
      check($sformatf("row%0d_lead_run", i), run, tbl[i].run);
      check($sformatf("row%0d_frame_len", i), fs_pos, FRAME);
      check($sformatf("row%0d_ready_low", i), rdy_low, FRAME - 1);
      check($sformatf("row%0d_no_underrun", i), ur_seen, 1'b0);
    end

    // ce every other clk, 12'hFFF in PWM: 8192-clk frame, one low tick
    ce = 1'b0;
    step();
    zeros  = 0;
    fs_pos = 0;
    n      = 0;
    for (int j = 1; j <= 2 * FRAME; j++) begin
      ce = j[0];
      step();
      if (dac_out === 1'b0) zeros++;
      if (frame_start === 1'b1) begin
        n++;
        if (fs_pos == 0) fs_pos = j + 1;
      end
    end
    ce = 1'b1;
    check("ce_half_zero_clks", zeros, 2);
    check("ce_half_frame_len", fs_pos, 2 * FRAME);
    check("ce_half_fs_count", n, 1);

    // reset mid-frame with a sample pending: it must never be rendered
    src_q.delete();
    rst = 1'b1;
    drive_src();
    step();
    rst = 1'b0;
    mode = MODE_PWM;
    src_q.push_back('h800);
    drive_src();
    wait_fs(FRAME + 16, n);
    check("rst_lead_frame_len", n, FRAME);
    src_q.push_back('h123);
    drive_src();
    repeat (100) step();
    check("rst_pre_ready", s_if.ready, 1'b0);
    check("rst_pre_dac", dac_out, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_dac_cleared", dac_out, 1'b0);
    check("rst_ready_set", s_if.ready, 1'b1);
    measure(FRAME, ones, run, fs_pos, rdy_low, ur_seen);
    check("rst_discarded_ones", ones, 0);
    check("rst_next_fs", fs_pos, FRAME);
    check("rst_underrun", ur_seen, 1'b1);

    // randomized traffic against the model
    src_auto = 1'b0;
    for (int k = 0; k < 16000; k++) begin
      rst        = ($urandom_range(0, 2999) == 0);
      ce         = ($urandom_range(0, 3) != 0);
      mode       = ($urandom_range(0, 1) == 1) ? MODE_SD : MODE_PWM;
      s_if.valid = ($urandom_range(0, 1499) == 0);
      s_if.data  = W'($urandom);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
